// File: rtl/featuremap_pad_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : featuremap_pad_sequencer
// Brief    : Wraps a show-ahead pixel stream in a one-pixel zero border and
//            emits a (WIDTH+2)x(HEIGHT+2) raster, one word per cycle.
//            Optional macro FEATUREMAP_PAD_SEQ_STALL_CNT_EN adds stall_cycles.
// Revision : 1.0 - initial release
// ============================================================================
module featuremap_pad_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] data_in,
  input  logic                    data_fifo_empty,
  input  logic                    stall,
  output logic                    rdreq,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    frame_done
`ifdef FEATUREMAP_PAD_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int c_pw    = WIDTH + 2;
  localparam int c_ph    = HEIGHT + 2;
  localparam int c_col_w = $clog2(c_pw);
  localparam int c_row_w = $clog2(c_ph);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(c_pw - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(c_ph - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]              r_state;
  logic [c_row_w-1:0]      r_row;
  logic [c_col_w-1:0]      r_col;
  logic [3*DATA_WIDTH-1:0] r_data_out;
  logic                    r_valid_out;
  logic                    r_busy;
  logic                    r_frame_done;

  logic w_run;
  logic w_border;
  logic w_emit;
  logic w_last;

  assign w_run    = (r_state == c_run);
  assign w_border = (r_row == '0) || (r_row == c_row_last) ||
                    (r_col == '0) || (r_col == c_col_last);
  // Border words are synthesised locally, so only interior words need a pixel.
  assign w_emit   = w_run && !stall && (w_border || !data_fifo_empty);
  assign rdreq    = w_run && !w_border && !stall && !data_fifo_empty;
  assign w_last   = (r_row == c_row_last) && (r_col == c_col_last);

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_idle;
      r_row        <= '0;
      r_col        <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_emit;
      // Pulses the cycle after DONE so it never overlaps the final word.
      r_frame_done <= (r_state == c_done);
      if (w_emit) begin
        r_data_out <= w_border ? '0 : data_in;
      end
      case (r_state)
        c_idle: begin
          if (start) begin
            r_state <= c_run;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        c_run: begin
          if (w_emit) begin
            if (w_last) begin
              r_state <= c_done;
              r_busy  <= 1'b0;
              r_row   <= '0;
              r_col   <= '0;
            end else if (r_col == c_col_last) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef FEATUREMAP_PAD_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  assign stall_cycles = r_stall_cycles;

  // A RUN cycle without an emit is exactly a stall or an interior bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if ((r_state == c_idle) && start) begin
      r_stall_cycles <= '0;
    end else if (w_run && !w_emit && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_featuremap_pad_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_featuremap_pad_sequencer
// Brief    : Scoreboard bench for featuremap_pad_sequencer on a 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_featuremap_pad_sequencer;

  localparam int DW     = 32;
  localparam int W      = 4;
  localparam int H      = 3;
  localparam int PW     = W + 2;
  localparam int PH     = H + 2;
  localparam int NWORDS = PW * PH;
  localparam int NPIX   = W * H;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [3*DW-1:0] data_in = '0;
  logic            data_fifo_empty = 1'b1;
  logic            stall = 1'b0;
  logic            rdreq;
  logic [3*DW-1:0] data_out;
  logic            valid_out;
  logic            busy;
  logic            frame_done;
`ifdef FEATUREMAP_PAD_SEQ_STALL_CNT_EN
  logic [31:0]     stall_cycles;
`endif

  always #5 clk = ~clk;

  featuremap_pad_sequencer #(
    .DATA_WIDTH (DW),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .data_in         (data_in),
    .data_fifo_empty (data_fifo_empty),
    .stall           (stall),
    .rdreq           (rdreq),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .busy            (busy),
    .frame_done      (frame_done)
`ifdef FEATUREMAP_PAD_SEQ_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  logic [3*DW-1:0] fifo[$];
  logic [3*DW-1:0] exp_q[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   rd_total    = 0;
  int   frames_done = 0;
  int   frame_words = 0;
  logic pop_q       = 1'b0;
  logic prev_valid  = 1'b0;

  task automatic check_w(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] pix(input int p);
    logic [DW-1:0] c;
    c = DW'(p);
    return {c, c, c};
  endfunction

  // Source FIFO pop bookkeeping: rdreq is sampled at the edge that consumes it.
  always @(posedge clk) begin
    pop_q <= rdreq;
    if (rdreq) rd_total <= rd_total + 1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      frame_words = 0;
      prev_valid  = 1'b0;
    end else begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: actual=%h required=none", data_out);
        end else begin
          check_w("word", data_out, exp_q.pop_front());
        end
        frame_words++;
      end
      if (frame_done) begin
        check_i("done_after_last", int'({prev_valid, valid_out}), 2);
        check_i("words_per_frame", frame_words, NWORDS);
        frames_done++;
        frame_words = 0;
      end
      prev_valid = valid_out;
    end
  end

  task automatic step(input logic s_start, input logic s_stall, input logic s_empty);
    @(negedge clk);
    if (pop_q && fifo.size() > 0) void'(fifo.pop_front());
    start           = s_start;
    stall           = s_stall;
    data_fifo_empty = s_empty || (fifo.size() == 0);
    data_in         = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic load_frame();
    int k;
    fifo.delete();
    for (int p = 1; p <= NPIX; p++) fifo.push_back(pix(p));
    k = 1;
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        if (r == 0 || r == PH-1 || c == 0 || c == PW-1) begin
          exp_q.push_back('0);
        end else begin
          exp_q.push_back(pix(k));
          k++;
        end
      end
    end
  endtask

  task automatic run_frame(input string tag, input int st_at, input int st_len,
                           input int em_at, input int em_len, input int x0,
                           input int x1, input int exp_stalls);
    int rd0;
    int fd0;
    load_frame();
    rd0 = rd_total;
    fd0 = frames_done;
    for (int i = 0; i < 45; i++) begin
      logic s_st;
      logic s_em;
      s_st = (i >= st_at) && (i < st_at + st_len);
      s_em = (i >= em_at) && (i < em_at + em_len);
      step((i == 0) || (i == x0) || (i == x1), s_st, s_em);
      if (s_st || s_em) begin
        #1 check_i({tag, "_rdreq_held"}, int'(rdreq), 0);
        @(posedge clk);
        #1 check_i({tag, "_valid_gap"}, int'(valid_out), 0);
      end
    end
    check_i({tag, "_rdreq_count"}, rd_total - rd0, NPIX);
    check_i({tag, "_frames"}, frames_done - fd0, 1);
    check_i({tag, "_fifo_drained"}, fifo.size(), 0);
    check_i({tag, "_busy_idle"}, int'(busy), 0);
    check_i({tag, "_exp_drained"}, exp_q.size(), 0);
`ifdef FEATUREMAP_PAD_SEQ_STALL_CNT_EN
    check_i({tag, "_stall_cycles"}, int'(stall_cycles), exp_stalls);
`else
    if (exp_stalls < 0) $display("note: negative stall expectation for %s", tag);
`endif
  endtask

  initial begin
    #3;
    check_w("rst_data_out", data_out, '0);
    check_i("rst_valid_out", int'(valid_out), 0);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_frame_done", int'(frame_done), 0);
    check_i("rst_rdreq", int'(rdreq), 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    run_frame("plain", -1, 0, -1, 0, -1, -1, 0);
    run_frame("bubble", -1, 0, 8, 3, -1, -1, 3);
    run_frame("top_stall", 3, 2, -1, 0, -1, -1, 2);
    run_frame("stray_start", -1, 0, -1, 0, 10, 31, 0);
    run_frame("second", -1, 0, -1, 0, -1, -1, 0);
    run_frame("stall_empty", 16, 1, 16, 1, -1, -1, 1);

    // Reset in the middle of a frame.
    load_frame();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && frame_words < 15; i++) step(1'b0, 1'b0, 1'b0);
    check_i("reach_word15", int'(frame_words >= 15), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_w("abort_data_out", data_out, '0);
    check_i("abort_valid_out", int'(valid_out), 0);
    check_i("abort_busy", int'(busy), 0);
    check_i("abort_rdreq", int'(rdreq), 0);
    exp_q.delete();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_frame("after_reset", -1, 0, -1, 0, -1, -1, 0);

    check_i("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
